// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential half-width multiplier.
package mult_seq_pkg;

    typedef enum logic [2:0] {
        MUL_IDLE = 3'd0,
        ALBL     = 3'd1,
        ALBH     = 3'd2,
        AHBL     = 3'd3,
        AHBH     = 3'd4,
        MUL_DONE = 3'd5
    } mult_fsm_e;

    // Widest product the negate helper handles; callers slice the low bits back out.
    localparam int unsigned NEG_MAX_W = 256;

    // Two's-complement negate; truncating the result keeps it correct modulo 2^N for any N <= NEG_MAX_W.
    function automatic logic [NEG_MAX_W-1:0] neg_2w(input logic [NEG_MAX_W-1:0] x);
        return ~x + NEG_MAX_W'(1);
    endfunction

endpackage

// File: rtl/mult_seq_pp.sv
// Half-width partial product: picks operand halves for the current state, returns the unsigned HxH product.
module mult_seq_pp
    import mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  mult_fsm_e          state,
    input  logic [WIDTH-1:0]   ma,
    input  logic [WIDTH-1:0]   mb,
    output logic [WIDTH-1:0]   pp
);

    localparam int unsigned H = WIDTH / 2;

    logic [H-1:0] xh;
    logic [H-1:0] yh;

    // Half selection: ALBL and idle states default to the low halves.
    always_comb begin
        xh = ma[H-1:0];
        yh = mb[H-1:0];
        case (state)
            ALBH: yh = mb[WIDTH-1:H];
            AHBL: xh = ma[WIDTH-1:H];
            AHBH: begin
                xh = ma[WIDTH-1:H];
                yh = mb[WIDTH-1:H];
            end
            default: ;
        endcase
    end

    // An HxH product always fits in WIDTH bits, so this never truncates.
    assign pp = WIDTH'(xh) * WIDTH'(yh);

endmodule

// File: rtl/mult_seq_halves.sv
// Multi-cycle WIDTHxWIDTH multiplier built from four half-width partial products.
module mult_seq_halves
    import mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 signed_i,
    input  logic                 kill_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic [2:0]           state_o
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned PW = 2 * WIDTH;

    mult_fsm_e        state;
    mult_fsm_e        state_nxt;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic             neg_q;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    result_q;
    logic [WIDTH-1:0] pp;

    logic             accept;
    logic             use_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             early;
    logic [PW-1:0]    pp_wide;
    logic [PW-1:0]    acc_mid;
    logic [PW-1:0]    final_sum;

    mult_seq_pp #(.WIDTH(WIDTH)) u_pp (
        .state (state),
        .ma    (ma),
        .mb    (mb),
        .pp    (pp)
    );

    // Operand capture decode and accumulator adders.
    always_comb begin
        accept     = valid_i && (state == MUL_IDLE);
        use_signed = SIGNED_EN && signed_i;
        a_mag      = (use_signed && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
        b_mag      = (use_signed && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
        early      = EARLY_OUT && (ma[WIDTH-1:H] == '0) && (mb[WIDTH-1:H] == '0);
        pp_wide    = PW'(pp);
        acc_mid    = acc + (pp_wide << H);
        final_sum  = acc + (pp_wide << WIDTH);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; kill overrides every advance outside idle.
    always_comb begin
        state_nxt = state;
        if (kill_i && (state != MUL_IDLE)) begin
            state_nxt = MUL_IDLE;
        end else begin
            case (state)
                MUL_IDLE: if (valid_i) state_nxt = ALBL;
                ALBL:     state_nxt = early ? MUL_DONE : ALBH;
                ALBH:     state_nxt = AHBL;
                AHBL:     state_nxt = AHBH;
                AHBH:     state_nxt = MUL_DONE;
                MUL_DONE: if (ready_i) state_nxt = MUL_IDLE;
                default:  state_nxt = MUL_IDLE;
            endcase
        end
    end

    // Output decode: everything comes from state or registers.
    always_comb begin
        ready_o  = (state == MUL_IDLE);
        valid_o  = (state == MUL_DONE);
        result_o = result_q;
        state_o  = state;
    end

    // Operand magnitudes, sign, accumulator and result register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ma       <= '0;
            mb       <= '0;
            neg_q    <= 1'b0;
            acc      <= '0;
            result_q <= '0;
        end else if (accept) begin
            ma    <= a_mag;
            mb    <= b_mag;
            neg_q <= use_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else if (!kill_i) begin
            case (state)
                ALBL: begin
                    acc <= pp_wide;
                    if (early) begin
                        result_q <= neg_q ? PW'(neg_2w(NEG_MAX_W'(pp_wide))) : pp_wide;
                    end
                end
                ALBH, AHBL: acc <= acc_mid;
                AHBH: result_q <= neg_q ? PW'(neg_2w(NEG_MAX_W'(final_sum))) : final_sum;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_halves.sv
// Directed self-checking bench for mult_seq_halves (WIDTH=32).
module tb_mult_seq_halves;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        signed_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] result_o;
    logic [2:0]  state_o;

    logic        valid_ne;
    logic        ready_ne_o;
    logic        kill_ne;
    logic        valid_ne_o;
    logic        ready_ne;
    logic [63:0] result_ne_o;
    logic [2:0]  state_ne_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_seq_halves #(.WIDTH(32), .SIGNED_EN(1'b1), .EARLY_OUT(1'b1)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .signed_i (signed_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .state_o  (state_o)
    );

    mult_seq_halves #(.WIDTH(32), .SIGNED_EN(1'b1), .EARLY_OUT(1'b0)) dut_ne (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .valid_i  (valid_ne),
        .ready_o  (ready_ne_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .signed_i (signed_i),
        .kill_i   (kill_ne),
        .valid_o  (valid_ne_o),
        .ready_i  (ready_ne),
        .result_o (result_ne_o),
        .state_o  (state_ne_o)
    );

    // Issue one operation on dut and wait (bounded) for valid_o; lat counts edges from the accept edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [63:0] res);
        a_i = a; b_i = b; signed_i = s; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic test_reset();
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (result_o !== 64'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    endtask

    task automatic test_unsigned_full();
        int lat; logic [63:0] res;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, res);
        n_cmp++; if (res !== 64'hFFFF_FFFE_0000_0001) begin n_err++; $display("FAIL unsigned_max_result: got %h want FFFFFFFE00000001", res); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL unsigned_max_latency: got %0d want 5", lat); end
        @(posedge clk); #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL unsigned_return_idle: got %b want 1", ready_o); end
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, lat, res);
        n_cmp++; if (res !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL unsigned_msb_result: got %h want 80000000", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        int lat; logic [63:0] res;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, lat, res);
        n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL signed_m1x1: got %h want FFFFFFFFFFFFFFFF", res); end
        @(posedge clk); #1;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat, res);
        n_cmp++; if (res !== 64'h4000_0000_0000_0000) begin n_err++; $display("FAIL signed_minxmin: got %h want 4000000000000000", res); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL signed_minxmin_latency: got %0d want 5", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_early_out();
        int lat; logic [63:0] res;
        run_op(32'd3, 32'd5, 1'b0, lat, res);
        n_cmp++; if (res !== 64'd15) begin n_err++; $display("FAIL early_result: got %0d want 15", res); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL early_latency: got %0d want 2", lat); end
        @(posedge clk); #1;
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, lat, res);
        n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_err++; $display("FAIL early_signed_result: got %h want FFFFFFFFFFFFFFF1", res); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL early_signed_latency: got %0d want 2", lat); end
        @(posedge clk); #1;
        // Same small operands on the instance built without early-out.
        a_i = 32'd3; b_i = 32'd5; signed_i = 1'b0; valid_ne = 1'b1;
        @(posedge clk); #1;
        valid_ne = 1'b0;
        lat = 1;
        while (!valid_ne_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL no_early_latency: got %0d want 5", lat); end
        n_cmp++; if (result_ne_o !== 64'd15) begin n_err++; $display("FAIL no_early_result: got %0d want 15", result_ne_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] res;
        ready_i = 1'b0;
        run_op(32'h0000_1234, 32'h0001_0000, 1'b0, lat, res);
        n_cmp++; if (res !== 64'h0000_0000_1234_0000) begin n_err++; $display("FAIL bp_result: got %h want 12340000", res); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 64'h0000_0000_1234_0000) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b result=%h want 1 0 12340000", i, valid_o, ready_o, result_o);
            end
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin n_err++; $display("FAIL bp_release: got ready=%b valid=%b want 1 0", ready_o, valid_o); end
        a_i = 32'd9; b_i = 32'd9; signed_i = 1'b0; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL bp_next_accept: got state %0d want 1", state_o); end
        @(posedge clk); #1;
        n_cmp++; if (valid_o !== 1'b1 || result_o !== 64'd81) begin n_err++; $display("FAIL bp_next_result: got valid=%b result=%0d want 1 81", valid_o, result_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_kill();
        int lat; logic [63:0] res; logic rose;
        a_i = 32'h1234_5678; b_i = 32'h0000_0002; signed_i = 1'b0; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL kill_reach_ahbl: got state %0d want 3", state_o); end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        n_cmp++; if (state_o !== 3'd0 || ready_o !== 1'b1) begin n_err++; $display("FAIL kill_to_idle: got state=%0d ready=%b want 0 1", state_o, ready_o); end
        rose = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (valid_o) rose = 1'b1;
        end
        n_cmp++; if (rose !== 1'b0) begin n_err++; $display("FAIL kill_no_valid: got rose=%b want 0", rose); end
        run_op(32'd7, 32'd6, 1'b0, lat, res);
        n_cmp++; if (res !== 64'd42) begin n_err++; $display("FAIL kill_followup: got %0d want 42", res); end
        @(posedge clk); #1;
        // Kill in DONE wins over a held-low ready_i.
        ready_i = 1'b0;
        run_op(32'd7, 32'd6, 1'b0, lat, res);
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        ready_i = 1'b1;
        n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_err++; $display("FAIL kill_in_done: got valid=%b ready=%b want 0 1", valid_o, ready_o); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] res;
        a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0; signed_i = 1'b0; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL rst_reach_albh: got state %0d want 2", state_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || result_o !== 64'h0 || ready_o !== 1'b1 || state_o !== 3'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got valid=%b result=%h ready=%b state=%0d want 0 0 1 0", valid_o, result_o, ready_o, state_o);
        end
        #2 rst_ni = 1'b1;
        @(posedge clk); #1;
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, lat, res);
        n_cmp++; if (res !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL rst_followup: got %h want 100000000", res); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL rst_followup_latency: got %0d want 5", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] res;
        run_op(32'h0001_0002, 32'h0003_0004, 1'b0, lat, res);
        n_cmp++; if (res !== 64'h0000_0003_000A_0008) begin n_err++; $display("FAIL b2b_first: got %h want 3000A0008", res); end
        @(posedge clk); #1;
        run_op(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, lat, res);
        n_cmp++; if (res !== 64'h0000_FFFE_0001_0000) begin n_err++; $display("FAIL b2b_second: got %h want FFFE00010000", res); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 5", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; a_i = '0; b_i = '0; signed_i = 1'b0;
        kill_i = 1'b0; ready_i = 1'b1;
        valid_ne = 1'b0; kill_ne = 1'b0; ready_ne = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_ni = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_unsigned_full();
        test_signed();
        test_early_out();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
